sma_add_arbiter: RTL and testbench

- Shares one combinational sign-magnitude adder (existing sign_magnitude_add) between NUM_REQ requesters in the fp16 datapath, e.g. mantissa alignment/add users.
- Uses round-robin arbitration, latches the granted operands and registers the result.
- Returns the result on a single response channel tagged with the requester id, using a valid/ready handshake.

---
 rtl/sma_pkg.sv | 10 +
 rtl/sign_magnitude_add.sv | 29 ++
 rtl/sma_rr_arbiter.sv | 30 +++
 rtl/sma_add_arbiter.sv | 115 +++++++++++
 tb/tb_sma_add_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sma_pkg.sv
// sma_pkg: shared types and constants for the sign-magnitude adder arbiter
package sma_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
    localparam int DEF_WIDTH = 16;
    localparam int OVF_CNT_W = 16;
endpackage

// File: rtl/sign_magnitude_add.sv
// sign_magnitude_add: combinational sign-magnitude adder
//   i_lhs_sign/i_lhs_magnitude, i_rhs_sign/i_rhs_magnitude : operands
//   o_sign/o_magnitude : result (zero is always positive)
//   o_overflow         : result magnitude needs WIDTH+1 bits
module sign_magnitude_add #(
    parameter int WIDTH = 16
) (
    input  logic             i_lhs_sign,
    input  logic [WIDTH-1:0] i_lhs_magnitude,
    input  logic             i_rhs_sign,
    input  logic [WIDTH-1:0] i_rhs_magnitude,
    output logic             o_sign,
    output logic [WIDTH-1:0] o_magnitude,
    output logic             o_overflow
);
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_dif;
    logic             w_l_ge;
    logic             w_same;
    assign w_same = i_lhs_sign == i_rhs_sign;
    assign w_add  = {1'b0, i_lhs_magnitude} + {1'b0, i_rhs_magnitude};
    assign w_l_ge = i_lhs_magnitude >= i_rhs_magnitude;
    assign w_dif  = w_l_ge ? i_lhs_magnitude - i_rhs_magnitude : i_rhs_magnitude - i_lhs_magnitude;
    assign o_magnitude = w_same ? w_add[WIDTH-1:0] : w_dif;
    assign o_overflow  = w_same & w_add[WIDTH];
    // the larger operand sets the sign; equal magnitudes cancel to +0
    assign o_sign = w_same ? (i_lhs_sign & |w_add)
                           : (w_l_ge ? (i_lhs_sign & |w_dif) : i_rhs_sign);
endmodule

// File: rtl/sma_rr_arbiter.sv
// sma_rr_arbiter: combinational round-robin pick
//   i_req : request vector
//   i_ptr : last winner; scan starts at i_ptr+1 and wraps
//   o_gnt : one-hot grant (zero when no request)
//   o_idx : encoded grant index
module sma_rr_arbiter
    import sma_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx
);
    logic w_found;
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_found && i_req[(int'(i_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                o_gnt[(int'(i_ptr) + i) % NUM_REQ] = 1'b1;
                o_idx = ID_W'((int'(i_ptr) + i) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/sma_add_arbiter.sv
// sma_add_arbiter: round-robin shares one sign-magnitude adder among NUM_REQ requesters
//   i_clk, i_rst_n (sync, active-low)
//   i_req_valid/o_req_ready : per-requester handshake, ready one-hot in IDLE
//   i_lhs_*/i_rhs_*         : packed per-requester operands, requester k at [k*WIDTH +: WIDTH]
//   o_rsp_valid/i_rsp_ready : response handshake carrying o_rsp_id, o_sign, o_magnitude, o_overflow
//   SMA_ADD_ARBITER_OVF_CNT_EN adds i_ovf_clr and saturating o_ovf_count of overflowed responses
module sma_add_arbiter
    import sma_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ-1:0]       i_lhs_sign,
    input  logic [NUM_REQ*WIDTH-1:0] i_lhs_magnitude,
    input  logic [NUM_REQ-1:0]       i_rhs_sign,
    input  logic [NUM_REQ*WIDTH-1:0] i_rhs_magnitude,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic                     o_sign,
    output logic [WIDTH-1:0]         o_magnitude,
`ifdef SMA_ADD_ARBITER_OVF_CNT_EN
    input  logic                     i_ovf_clr,
    output logic [OVF_CNT_W-1:0]     o_ovf_count,
`endif
    output logic                     o_overflow
);
    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic               r_lhs_sign;
    logic [WIDTH-1:0]   r_lhs_mag;
    logic               r_rhs_sign;
    logic [WIDTH-1:0]   r_rhs_mag;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_sum_sign;
    logic [WIDTH-1:0]   w_sum_mag;
    logic               w_sum_ovf;

    sma_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    sign_magnitude_add #(.WIDTH(WIDTH)) u_add (
        .i_lhs_sign      (r_lhs_sign),
        .i_lhs_magnitude (r_lhs_mag),
        .i_rhs_sign      (r_rhs_sign),
        .i_rhs_magnitude (r_rhs_mag),
        .o_sign          (w_sum_sign),
        .o_magnitude     (w_sum_mag),
        .o_overflow      (w_sum_ovf)
    );

    // ready is masked during reset so no request is acknowledged at a resetting edge
    always_comb begin
        o_req_ready = (r_state == ST_IDLE && i_rst_n) ? w_gnt : '0;
        o_rsp_valid = r_state == ST_RESP;
        w_next = r_state == ST_IDLE ? (|o_req_ready ? ST_EXEC : ST_IDLE) :
                 r_state == ST_EXEC ? ST_RESP :
                 (r_state == ST_RESP && !i_rsp_ready) ? ST_RESP : ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_lhs_sign  <= 1'b0;
            r_lhs_mag   <= '0;
            r_rhs_sign  <= 1'b0;
            r_rhs_mag   <= '0;
            o_rsp_id    <= '0;
            o_sign      <= 1'b0;
            o_magnitude <= '0;
            o_overflow  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (|o_req_ready) begin
                r_ptr      <= w_idx;
                r_id       <= w_idx;
                r_lhs_sign <= i_lhs_sign[w_idx];
                r_lhs_mag  <= i_lhs_magnitude[int'(w_idx)*WIDTH +: WIDTH];
                r_rhs_sign <= i_rhs_sign[w_idx];
                r_rhs_mag  <= i_rhs_magnitude[int'(w_idx)*WIDTH +: WIDTH];
            end
            if (r_state == ST_EXEC) begin
                o_rsp_id    <= r_id;
                o_sign      <= w_sum_sign;
                o_magnitude <= w_sum_mag;
                o_overflow  <= w_sum_ovf;
            end
        end
    end

`ifdef SMA_ADD_ARBITER_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_cnt;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_ovf_clr)
            r_ovf_cnt <= '0;
        else if (o_rsp_valid && i_rsp_ready && o_overflow && r_ovf_cnt != '1)
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
    assign o_ovf_count = r_ovf_cnt;
`endif
endmodule

// File: tb/tb_sma_add_arbiter.sv
// tb_sma_add_arbiter: scoreboard bench for sma_add_arbiter
module tb_sma_add_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        int t;
        int id;
        bit s;
        int m;
        bit o;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   lhs_s;
    logic [N*W-1:0] lhs_m;
    logic [N-1:0]   rhs_s;
    logic [N*W-1:0] rhs_m;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic           sign;
    logic [W-1:0]   mag;
    logic           ovf;
`ifdef SMA_ADD_ARBITER_OVF_CNT_EN
    logic           ovf_clr;
    logic [15:0]    ovf_count;
    int             cnt_model;
`endif

    exp_t         q[$];
    int           total;
    int           bad;
    int           cyc;
    int           done_cyc;
    int           last;
    logic [N-1:0] acc_vec;
    logic [N-1:0] exp_rdy;
    bit           busy;
    bit           prev_rst;
    bit           exp_v;

    sma_add_arbiter dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_lhs_sign      (lhs_s),
        .i_lhs_magnitude (lhs_m),
        .i_rhs_sign      (rhs_s),
        .i_rhs_magnitude (rhs_m),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_rsp_id        (rsp_id),
        .o_sign          (sign),
        .o_magnitude     (mag),
`ifdef SMA_ADD_ARBITER_OVF_CNT_EN
        .i_ovf_clr       (ovf_clr),
        .o_ovf_count     (ovf_count),
`endif
        .o_overflow      (ovf)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0d want=%0d", nm, cyc, act, want);
        end
    endtask

    // reference: exact signed integer sum, then split into sign / magnitude / overflow
    function automatic exp_t model(int id, bit ls, int lm, bit rs, int rm, int t);
        exp_t e;
        int s;
        int a;
        s = (ls ? -lm : lm) + (rs ? -rm : rm);
        a = s < 0 ? -s : s;
        e.t = t;
        e.id = id;
        e.s = s < 0;
        e.m = a % 65536;
        e.o = a >= 65536;
        return e;
    endfunction

    function automatic logic [N-1:0] rr(logic [N-1:0] v, int lst);
        for (int i = 1; i <= N; i++) begin
            int k = (lst + i) % N;
            if (v[k]) return N'(1 << k);
        end
        return '0;
    endfunction

    function automatic int rmag();
        int r = $urandom % 4;
        return r == 0 ? 65535 : r == 1 ? int'($urandom % 8) : int'($urandom % 65536);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // request side: arbitration model and scoreboard push
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last = N - 1;
            acc_vec = '0;
        end else begin
            busy = q.size() != 0 || done_cyc == cyc;
            exp_rdy = busy ? '0 : rr(req_valid, last);
            chk("req_ready", req_ready, exp_rdy);
            acc_vec = exp_rdy;
            for (int k = 0; k < N; k++)
                if (exp_rdy[k]) begin
                    q.push_back(model(k, lhs_s[k], int'(lhs_m[k*W +: W]), rhs_s[k], int'(rhs_m[k*W +: W]), cyc));
                    last = k;
                end
        end
    end

    // response side: latency, contents, stability under back-pressure, pop on handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rst = 1;
`ifdef SMA_ADD_ARBITER_OVF_CNT_EN
            cnt_model = 0;
`endif
        end else begin
            if (prev_rst) begin
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_id", rsp_id, 0);
                chk("rst_sign", sign, 0);
                chk("rst_magnitude", mag, 0);
                chk("rst_overflow", ovf, 0);
            end
            prev_rst = 0;
            exp_v = q.size() != 0 && cyc >= q[0].t + 2;
            chk("rsp_valid", rsp_valid, exp_v);
            if (exp_v && rsp_valid) begin
                chk("rsp_id", rsp_id, q[0].id);
                chk("sign", sign, q[0].s);
                chk("magnitude", mag, q[0].m);
                chk("overflow", ovf, q[0].o);
            end
`ifdef SMA_ADD_ARBITER_OVF_CNT_EN
            chk("ovf_count", ovf_count, cnt_model);
            if (ovf_clr) cnt_model = 0;
            else if (exp_v && rsp_ready && q[0].o && cnt_model != 65535) cnt_model++;
`endif
            if (exp_v && rsp_ready) begin
                void'(q.pop_front());
                done_cyc = cyc;
            end
        end
    end

    task automatic set_op(int k, bit ls, int lm, bit rs, int rm);
        lhs_s[k] = ls;
        lhs_m[k*W +: W] = W'(lm);
        rhs_s[k] = rs;
        rhs_m[k*W +: W] = W'(rm);
    endtask

    task automatic rand_op(int k);
        set_op(k, 1'($urandom % 2), rmag(), 1'($urandom % 2), rmag());
    endtask

    task automatic issue(int k, bit ls, int lm, bit rs, int rm);
        bit got = 0;
        set_op(k, ls, lm, rs, rm);
        req_valid[k] = 1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            #1;
            got = acc_vec[k];
        end
        req_valid[k] = 0;
        chk("accept_timeout", got, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rand_cycles(int n, int pv, int prdy);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc_vec[k] || !req_valid[k]) begin
                    req_valid[k] = ($urandom % 100) < pv;
                    rand_op(k);
                end else if (pv < 100 && $urandom % 32 == 0) begin
                    req_valid[k] = 0;
                end
            end
            rsp_ready = ($urandom % 100) < prdy;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        done_cyc = -1;
        last = N - 1;
        acc_vec = '0;
        rst_n = 0;
        req_valid = '0;
        lhs_s = '0;
        lhs_m = '0;
        rhs_s = '0;
        rhs_m = '0;
        rsp_ready = 0;
`ifdef SMA_ADD_ARBITER_OVF_CNT_EN
        ovf_clr = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        rsp_ready = 1;
        issue(0, 0, 3, 1, 5);
        drain();
        issue(2, 1, 65535, 1, 1);
        drain();
        issue(1, 0, 7, 1, 7);
        drain();
        issue(3, 1, 0, 1, 0);
        drain();
        for (int k = 0; k < N; k++) begin
            rand_op(k);
            req_valid[k] = 1;
        end
        rand_cycles(20, 100, 100);
        req_valid = '0;
        drain();
        rsp_ready = 0;
        issue(1, 0, 100, 0, 200);
        rand_cycles(8, 100, 0);
        rand_cycles(12, 100, 100);
        req_valid = '0;
        rsp_ready = 1;
        drain();
        issue(0, 0, 5, 0, 6);
        rst_n = 0;
        for (int k = 0; k < N; k++) begin
            rand_op(k);
            req_valid[k] = 1;
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        rand_cycles(12, 100, 100);
        rand_cycles(1500, 40, 70);
`ifdef SMA_ADD_ARBITER_OVF_CNT_EN
        ovf_clr = 1;
        @(posedge clk);
        #1;
        ovf_clr = 0;
`endif
        rand_cycles(1500, 60, 50);
        req_valid = '0;
        rsp_ready = 1;
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
